// File: rtl/pipe_hazard_ctrl_pkg.sv
// rtl/pipe_hazard_ctrl_pkg.sv - shared constants for the hazard/forwarding controller
package pipe_hazard_ctrl_pkg;

    // Width of the forwarding-source selects (stage indices 0..7)
    localparam int FWD_W = 3;

    // Forwarding select value meaning "take the operand from the register file"
    localparam logic [FWD_W-1:0] FWD_RF = '0;

    // Scoreboard index of the E stage (youngest tracked writer)
    localparam int STG_E = 1;

endpackage

// File: rtl/pipe_hazard_ctrl_match.sv
// rtl/pipe_hazard_ctrl_match.sv - priority search of the writer scoreboard for one ID operand
//
// Ports:
//   src_i     operand register address
//   use_i     the ID instruction actually reads this operand
//   v_i       per-stage valid bits, index 1 = E
//   rn_i      per-stage destination registers, stage k at bits [(k-1)*RW +: RW]
//   ld_i      per-stage "writer is a load" bits
//   hit_o     some in-flight writer targets the operand
//   k_o       stage index of the youngest matching writer (FWD_RF when no hit)
//   ld_o      the selected writer is a load
module pipe_hazard_ctrl_match
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int RW   = 5,
    parameter int NSTG = 2
) (
    input  logic [RW-1:0]      src_i,
    input  logic               use_i,
    input  logic [NSTG:1]      v_i,
    input  logic [NSTG*RW-1:0] rn_i,
    input  logic [NSTG:1]      ld_i,
    output logic               hit_o,
    output logic [FWD_W-1:0]   k_o,
    output logic               ld_o
);

    // Scan oldest to youngest so the last (youngest) match overrides.
    // Register 0 is hard-wired zero and is never forwarded.
    always_comb begin
        hit_o = 1'b0;
        k_o   = FWD_RF;
        ld_o  = 1'b0;
        for (int i = NSTG; i >= STG_E; i--) begin
            if (use_i && (src_i != '0) && v_i[i] && (rn_i[(i-1)*RW +: RW] == src_i)) begin
                hit_o = 1'b1;
                k_o   = FWD_W'(i);
                ld_o  = ld_i[i];
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - hazard detection, operand forwarding select and stall counting
//
// Ports:
//   clock, resetn        rising-edge clock, asynchronous active-low reset
//   id_rs, id_rt         ID source registers A/B, qualified by id_use_rs/id_use_rt
//   id_rn, id_wreg       ID destination register and its write enable
//   id_m2reg             ID instruction is a load
//   id_kill              ID instruction enters E as a bubble
//   mem_busy             data memory not ready, freezes the pipe
//   stall, bubble        PC/IR hold and E control-word squash
//   fwda, fwdb           forwarding stage per operand (0 = regfile)
//   fwda_ld, fwdb_ld     selected forwarding source is load data
//   stall_cnt            saturating count of load-use bubble cycles
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int RW       = 5,
    parameter int NSTG     = 2,
    parameter int LOAD_STG = 2,
    parameter int CNT_W    = 16
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic [RW-1:0]    id_rs,
    input  logic [RW-1:0]    id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic [RW-1:0]    id_rn,
    input  logic             id_wreg,
    input  logic             id_m2reg,
    input  logic             id_kill,
    input  logic             mem_busy,
    output logic             stall,
    output logic             bubble,
    output logic [FWD_W-1:0] fwda,
    output logic [FWD_W-1:0] fwdb,
    output logic             fwda_ld,
    output logic             fwdb_ld,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [FWD_W-1:0] LOAD_K = FWD_W'(LOAD_STG);

    logic [NSTG:1]         v_q, v_d;
    logic [NSTG:1]         ld_q, ld_d;
    logic [NSTG:1][RW-1:0] rn_q, rn_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic             hit_a, hit_b;
    logic [FWD_W-1:0] k_a, k_b;
    logic             ld_a, ld_b;
    logic             lu;

    pipe_hazard_ctrl_match #(.RW(RW), .NSTG(NSTG)) u_match_a (
        .src_i (id_rs),
        .use_i (id_use_rs),
        .v_i   (v_q),
        .rn_i  (rn_q),
        .ld_i  (ld_q),
        .hit_o (hit_a),
        .k_o   (k_a),
        .ld_o  (ld_a)
    );

    pipe_hazard_ctrl_match #(.RW(RW), .NSTG(NSTG)) u_match_b (
        .src_i (id_rt),
        .use_i (id_use_rt),
        .v_i   (v_q),
        .rn_i  (rn_q),
        .ld_i  (ld_q),
        .hit_o (hit_b),
        .k_o   (k_b),
        .ld_o  (ld_b)
    );

    // A load whose data is not yet out of memory cannot be forwarded: hold ID.
    assign lu = (hit_a & ld_a & (k_a < LOAD_K)) | (hit_b & ld_b & (k_b < LOAD_K));

    assign stall     = lu | mem_busy;
    assign bubble    = lu & ~mem_busy;
    assign fwda      = k_a;
    assign fwdb      = k_b;
    assign fwda_ld   = ld_a;
    assign fwdb_ld   = ld_b;
    assign stall_cnt = cnt_q;

    // Shadow scoreboard advances with the pipe; mem_busy freezes every entry,
    // which also makes id_kill a no-op until the pipe moves again.
    always_comb begin
        v_d  = v_q;
        rn_d = rn_q;
        ld_d = ld_q;
        if (!mem_busy) begin
            for (int k = NSTG; k > STG_E; k--) begin
                v_d[k]  = v_q[k-1];
                rn_d[k] = rn_q[k-1];
                ld_d[k] = ld_q[k-1];
            end
            v_d[STG_E]  = ~(bubble | id_kill) & id_wreg & (id_rn != '0);
            rn_d[STG_E] = id_rn;
            ld_d[STG_E] = id_m2reg;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (bubble && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            v_q   <= '0;
            rn_q  <= '0;
            ld_q  <= '0;
            cnt_q <= '0;
        end else begin
            v_q   <= v_d;
            rn_q  <= rn_d;
            ld_q  <= ld_d;
            cnt_q <= cnt_d;
        end
    end

endmodule
